bcd_to_binary: RTL and testbench
================================

Name: bcd_to_binary

Overview:
- Sequential packed-BCD to unsigned binary converter. Uses reverse double-dabble: shift right, then subtract 3 from any digit >= 8.
- Inverse of the team's binary-to-BCD converter and shares its start/done handshake style.
- Takes keypad/display-side decimal values (4 digits, 0..9999) and returns a 14-bit binary value for the arithmetic datapath.

Parameters:
- DIGITS, 4, number of BCD digits on the input (input width 4*DIGITS).
- BIN_W, 14, output width and iteration count. Must satisfy 2^BIN_W > 10^DIGITS - 1. Only the defaults are verified.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- bcd  input  4*DIGITS  packed BCD; digit 0 is in bits [3:0]; sampled only when start is accepted
- start  input  1  request; accepted only in IDLE (see Optional Feature)
- busy  output  1  high while a conversion is in progress
- done  output  1  result valid; level, not pulse
- err  output  1  an input digit was > 9 at the accepted start
- binary  output  BIN_W  converted value; registered

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE.
  - busy = 0, done = 0, err = 0, binary = 0.
  - Internal shift registers and counter are cleared.
  - Reset mid-conversion aborts it immediately; no done follows.
- Internal registers: bcd_reg (4*DIGITS), acc (BIN_W), cnt (ceil(log2(BIN_W+1)) bits).
- IDLE:
  - On a clk edge with start = 1: bcd_reg <= bcd, acc <= 0, cnt <= 0, busy <= 1, done <= 0.
  - err <= 1 if any 4-bit digit of bcd > 9, else err <= 0. The state goes to SHIFT.
  - binary holds its previous value until the new result is written.
- SHIFT:
  - {bcd_reg, acc} <= {bcd_reg, acc} >> 1. acc[BIN_W-1] receives bcd_reg[0]; a 0 enters the bcd_reg MSB.
  - cnt <= cnt + 1. The state goes to ADJUST.
- ADJUST:
  - Every digit of bcd_reg that is >= 8 is decremented by 3. All digits are adjusted in parallel, 4-bit arithmetic, no cross-digit carry.
  - If cnt == BIN_W: write binary (acc, or 0 when err = 1), done <= 1, busy <= 0, state goes to IDLE.
  - Otherwise the state goes to SHIFT.
- Latency:
  - Exactly 2*BIN_W clock edges after the accepting edge (28 at default).
  - done and binary are visible together after the 28th edge.
  - Latency is fixed and independent of the value, including err cases.
- done:
  - Stays 1 until the next accepted start, which clears it on the accepting edge.
  - Reset also clears it.
- Back-to-back: start held high while done = 1 and state = IDLE is accepted on that edge. done falls and a new conversion begins.
- err: valid together with done and holds with it. When err = 1, binary is forced to 0.
- Inputs are not sampled outside the accepting edge. Changing bcd during busy has no effect.
- Default (macro undefined): start while busy is ignored.

Optional Feature:
- Macro: BCD2BIN_RESTART_EN.
- Defined:
  - start = 1 in SHIFT or ADJUST aborts the current conversion.
  - It reloads bcd_reg, acc and cnt from the new bcd, recomputes err, and continues in SHIFT.
  - Latency restarts from that edge (2*BIN_W edges). No done is produced for the aborted conversion.
  - busy stays 1 throughout.
- Undefined: start during busy is ignored, as in Behaviour.

Test Plan:
- Reset, then start with bcd = 16'h0000 -> after 28 edges, done = 1, binary = 0, err = 0, busy = 0. Earlier, busy = 1 and done = 0 for edges 1..27.
- bcd = 16'h9999 -> binary = 14'd9999 (0x270F) and done after exactly 28 edges. bcd = 16'h1234 -> binary = 1234 (0x4D2). bcd = 16'h0809 -> 809.
- Invalid bcd = 16'h12A4 -> after 28 edges, done = 1, err = 1, binary = 0. A following valid start of 16'h0042 -> err = 0, binary = 42.
- Assert rst_n = 0 asynchronously mid-edge at cycle 10 of a 16'h5678 conversion -> busy, done, err and binary go to 0 immediately, with no done afterwards. A new start of 16'h0001 -> binary = 1 after 28 edges.
- Start of 16'h0005, then at cycle 5 pulse start with bcd = 16'h0007:
  - Macro undefined -> binary = 5 after 28 edges from the first start.
  - Macro defined -> binary = 7 after 28 edges from the second start, with no intermediate done.
- Hold start = 1 continuously with bcd = 16'h0100 -> done pulses high for exactly one cycle every 29 cycles, binary = 100, and busy is low only in the done cycles.

Source files
------------

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter using reverse double-dabble (shift right, then -3 on digits >= 8).
// Optional BCD2BIN_RESTART_EN: a start while busy aborts and reloads the conversion.
module bcd_to_binary #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      binary
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, ADJUST} state_t;

  state_t             state, state_nxt;
  logic [BCD_W-1:0]   bcd_reg;
  logic [BIN_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               load, do_shift, do_adj, finish;

  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // Digits adjusted independently; no carry crosses a digit boundary.
  function automatic logic [BCD_W-1:0] adjust_digits(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] >= 4'd8) r[4*i +: 4] = v[4*i +: 4] - 4'd3;
    return r;
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    do_shift  = 1'b0;
    do_adj    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        do_shift  = 1'b1;
        state_nxt = ADJUST;
      end
      ADJUST: begin
        do_adj = 1'b1;
        if (cnt == CNT_W'(BIN_W)) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = SHIFT;
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef BCD2BIN_RESTART_EN
    if (start && state != IDLE) begin
      load      = 1'b1;
      do_shift  = 1'b0;
      do_adj    = 1'b0;
      finish    = 1'b0;
      state_nxt = SHIFT;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_reg <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      binary  <= '0;
    end else if (load) begin
      bcd_reg <= bcd;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b1;
      done    <= 1'b0;
      err     <= has_bad_digit(bcd);
    end else if (do_shift) begin
      {bcd_reg, acc} <= {bcd_reg, acc} >> 1;
      cnt            <= cnt + CNT_W'(1);
    end else if (do_adj) begin
      bcd_reg <= adjust_digits(bcd_reg);
      if (finish) begin
        binary <= err ? '0 : acc;
        done   <= 1'b1;
        busy   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: directed cases plus random BCD values against a decimal model.
// Build with +define+BCD2BIN_RESTART_EN to check the restart-on-start behaviour.
module tb_bcd_to_binary;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int LAT    = 2 * BIN_W;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [4*DIGITS-1:0] bcd = '0;
  logic                start = 1'b0;
  logic                busy, done, err;
  logic [BIN_W-1:0]    binary;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .start(start),
    .busy(busy), .done(done), .err(err), .binary(binary)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Decimal reference: weight each nibble by its power of ten.
  task automatic model(input logic [15:0] v, output int bin, output int bad);
    int w;
    bin = 0; bad = 0; w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      int d;
      d = (v >> (4 * i)) & 15;
      if (d > 9) bad = 1;
      bin += d * w;
      w *= 10;
    end
    if (bad) bin = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_conv(input logic [15:0] v, input string tag);
    int exp_bin, exp_err, early;
    model(v, exp_bin, exp_err);
    bcd = v; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_start"}, busy, 1);
    check({tag, "_done_start"}, done, 0);
    early = 0;
    for (int e = 1; e < LAT; e++) begin
      bcd = 16'($urandom);
      tick();
      if (done || !busy) early++;
    end
    check({tag, "_early"}, early, 0);
    tick();
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_bin"}, binary, exp_bin);
  endtask

  initial begin
    int first, got_bin, ndone, badpos, badval, badbusy, spurious;
    int exp_edge, exp_val;
    logic [15:0] v;

    #12 rst_n = 1'b1;
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_bin", binary, 0);

    run_conv(16'h0000, "zero");
    run_conv(16'h9999, "max");
    run_conv(16'h1234, "d1234");
    run_conv(16'h0809, "d0809");
    run_conv(16'h12A4, "bad");
    run_conv(16'h0042, "after_bad");

    // Asynchronous reset in the middle of a cycle aborts the conversion.
    bcd = 16'h5678; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    check("arst_bin", binary, 0);
    tick();
    rst_n = 1'b1;
    spurious = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (done || busy) spurious++;
    end
    check("arst_no_done", spurious, 0);
    run_conv(16'h0001, "post_rst");

    // Start pulse while busy.
    bcd = 16'h0005; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    bcd = 16'h0007; start = 1'b1;
    tick();
    start = 1'b0;
    bcd = 16'h0003;
    first = -1; got_bin = -1;
    for (int e = 6; e <= 45; e++) begin
      tick();
      if (done && first < 0) begin
        first = e;
        got_bin = binary;
      end
    end
`ifdef BCD2BIN_RESTART_EN
    exp_edge = 5 + LAT; exp_val = 7;
`else
    exp_edge = LAT; exp_val = 5;
`endif
    check("midstart_edge", first, exp_edge);
    check("midstart_bin", got_bin, exp_val);

    // Start held high: back-to-back conversions every LAT+1 cycles.
    bcd = 16'h0100; start = 1'b1;
    tick();
    ndone = 0; badpos = 0; badval = 0; badbusy = 0;
    for (int e = 1; e <= 95; e++) begin
      tick();
      if (done) begin
        ndone++;
        if ((e - LAT) % (LAT + 1) != 0) badpos++;
        if (binary != 14'd100) badval++;
      end
      if (busy == done) badbusy++;
    end
    start = 1'b0;
    check("b2b_count", ndone, 3);
    check("b2b_period", badpos, 0);
    check("b2b_value", badval, 0);
    check("b2b_busy", badbusy, 0);
    repeat (LAT + 2) tick();

    // Random values, occasionally with an illegal digit.
    for (int n = 0; n < 16; n++) begin
      v = '0;
      for (int i = 0; i < DIGITS; i++)
        v[4*i +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0)
        v[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      run_conv(v, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
